// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and the boundary-mode enum for the Gray up/down/load counter.
// The functions work on a wide word; callers zero-extend in and truncate out.
package gray_pkg;

  localparam int GW_MAX = 64;

  typedef logic [GW_MAX-1:0] gword_t;

  typedef enum logic {WRAP = 1'b0, SAT = 1'b1} mode_e;

  function automatic gword_t bin2gray(input gword_t b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero upper bits leave the result unchanged.
  function automatic gword_t gray2bin(input gword_t g);
    gword_t b;
    b[GW_MAX-1] = g[GW_MAX-1];
    for (int i = GW_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_conv.sv
// Combinational Gray->binary decode with terminal-value flags.
module gray_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o,
  output logic             at_max_o,
  output logic             at_min_o
);

  assign bin_o    = WIDTH'(gray2bin(gword_t'(gray_i)));
  assign at_max_o = &bin_o;
  assign at_min_o = ~|bin_o;

endmodule

// File: rtl/gray_udl_param.sv
// Parametrised Gray up/down/load counter with wrap or saturate boundaries,
// binary decode, terminal flags and a registered one-cycle boundary pulse.
module gray_udl_param
  import gray_pkg::*;
#(
  parameter int               WIDTH      = 4,
  parameter int               SATURATE   = 0,
  parameter logic [WIDTH-1:0] RESET_GRAY = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_bin,
  output logic             at_max,
  output logic             at_min,
  output logic             boundary
);

  localparam mode_e MODE = (SATURATE != 0) ? SAT : WRAP;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic             boundary_q, boundary_d;
  logic [WIDTH-1:0] bin_nxt;
  logic             blocked;

  // One decoder serves both the count_bin output and the step arithmetic.
  gray_conv #(.WIDTH(WIDTH)) u_conv (
    .gray_i   (count_q),
    .bin_o    (count_bin),
    .at_max_o (at_max),
    .at_min_o (at_min)
  );

  assign bin_nxt = up ? (count_bin + ONE) : (count_bin - ONE);
  assign blocked = up ? at_max : at_min;

  always_comb begin
    count_d    = count_q;
    boundary_d = 1'b0;
    if (load_en) begin
      count_d = load_value;
    end else if (en) begin
      boundary_d = blocked;
      // Binary add/sub wraps naturally; saturate mode just suppresses the update.
      if (!(blocked && MODE == SAT)) begin
        count_d = WIDTH'(bin2gray(gword_t'(bin_nxt)));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= RESET_GRAY;
      boundary_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      boundary_q <= boundary_d;
    end
  end

  assign count    = count_q;
  assign boundary = boundary_q;

  a_single_bit_step: assert property (
    @(posedge clk) disable iff (reset)
    (en && !load_en && !(blocked && MODE == SAT)) |=> $onehot(count ^ $past(count))
  );

endmodule
